// File: rtl/bit8_down_timer_v.sv
// 8-bit presettable down timer with a 74-style ripple terminal count,
// a reload register for periodic ticks, and an IDLE/RUN/DONE state machine.
module bit8_down_timer_v (
    input  logic       CP,
    input  logic       MR,
    input  logic       PEn,
    input  logic [7:0] D,
    input  logic       CET,
    input  logic       CEP,
    input  logic       ARE,
    output logic [7:0] Q,
    output logic       TC,
    output logic       DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rld_q, rld_d;

    logic run;
    logic en;
    logic cnt_zero;
    logic lo_zero;
    logic reload_ok;
    logic tc_o;
    logic done_o;

    assign run       = (state_q == S_RUN);
    assign en        = CET & CEP & run;
    assign cnt_zero  = (cnt_q == 8'h00);
    assign lo_zero   = (cnt_q[3:0] == 4'h0);
    assign reload_ok = ARE & (rld_q != 8'h00);

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'h00;
            rld_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (!PEn) state_d = S_RUN;
            end
            S_RUN: begin
                if (PEn && en && cnt_zero && !reload_ok)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // High nibble only borrows from an exhausted low nibble; never wraps from 0.
    always_comb begin
        cnt_d = cnt_q;
        rld_d = rld_q;
        if (!PEn) begin
            cnt_d = D;
            rld_d = D;
        end else if (en) begin
            if (!cnt_zero) begin
                cnt_d[3:0] = cnt_q[3:0] - 4'd1;
                if (lo_zero) cnt_d[7:4] = cnt_q[7:4] - 4'd1;
            end else if (reload_ok) begin
                cnt_d = rld_q;
            end
        end
    end

    always_comb begin
        tc_o   = CET & cnt_zero & run;
        done_o = (state_q == S_DONE);
    end

    assign Q    = cnt_q;
    assign TC   = tc_o;
    assign DONE = done_o;

endmodule

// File: tb/tb_bit8_down_timer_v.sv
// Directed bench for bit8_down_timer_v: a behavioural model is compared
// every falling edge, plus literal checks that pin the expected sequences.
module tb_bit8_down_timer_v;

    logic       CP = 1'b0;
    logic       MR;
    logic       PEn;
    logic [7:0] D;
    logic       CET;
    logic       CEP;
    logic       ARE;
    logic [7:0] Q;
    logic       TC;
    logic       DONE;

    int n_chk  = 0;
    int n_fail = 0;

    bit8_down_timer_v dut (
        .CP(CP), .MR(MR), .PEn(PEn), .D(D),
        .CET(CET), .CEP(CEP), .ARE(ARE),
        .Q(Q), .TC(TC), .DONE(DONE)
    );

    always #5 CP = ~CP;

    // Model: plain count value, reload value and mode (0 idle, 1 run, 2 done)
    logic [7:0] mq  = 8'h00;
    logic [7:0] mr  = 8'h00;
    int         mst = 0;

    always @(posedge CP or posedge MR) begin
        if (MR) begin
            mq  = 8'h00;
            mr  = 8'h00;
            mst = 0;
        end else if (!PEn) begin
            mq  = D;
            mr  = D;
            mst = 1;
        end else if (CET && CEP && mst == 1) begin
            if (mq != 0)                  mq  = mq - 8'd1;
            else if (ARE && mr != 0)      mq  = mr;
            else                          mst = 2;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CP) begin
        chk("model_q", Q, mq);
        chk("model_tc", {7'd0, TC},
            {7'd0, (CET && mq == 0 && mst == 1)});
        chk("model_done", {7'd0, DONE}, {7'd0, (mst == 2)});
    end

    task automatic apply(input logic pen, input logic [7:0] d,
                         input logic cet, input logic cep, input logic are);
        PEn = pen;
        D   = d;
        CET = cet;
        CEP = cep;
        ARE = are;
        @(posedge CP);
        #2;
    endtask

    int pulses;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        MR = 1'b1; PEn = 1'b1; D = 8'h00;
        CET = 1'b1; CEP = 1'b1; ARE = 1'b0;
        #3;
        chk("rst_q", Q, 8'h00);
        chk("rst_tc", {7'd0, TC}, 8'h00);
        chk("rst_done", {7'd0, DONE}, 8'h00);
        #9 MR = 1'b0;
        @(posedge CP); #2;

        // Async reset mid-run
        apply(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("load_5a", Q, 8'h5A);
        #1 MR = 1'b1;
        #1;
        chk("amr_q", Q, 8'h00);
        chk("amr_tc", {7'd0, TC}, 8'h00);
        chk("amr_done", {7'd0, DONE}, 8'h00);
        #2 MR = 1'b0;
        for (int i = 0; i < 5; i++) apply(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("idle_hold", Q, 8'h00);

        // One-shot from 3
        apply(1'b0, 8'h03, 1'b1, 1'b1, 1'b0);
        chk("os_03", Q, 8'h03);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("os_02", Q, 8'h02);
        chk("os_tc0", {7'd0, TC}, 8'h00);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("os_01", Q, 8'h01);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("os_00", Q, 8'h00);
        chk("os_tc1", {7'd0, TC}, 8'h01);
        chk("os_nd", {7'd0, DONE}, 8'h00);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("os_done", {7'd0, DONE}, 8'h01);
        chk("os_tcd", {7'd0, TC}, 8'h00);
        for (int i = 0; i < 10; i++) apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("os_stay", Q, 8'h00);
        chk("os_stayd", {7'd0, DONE}, 8'h01);

        // Nibble borrow and zero load
        apply(1'b0, 8'h10, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("borrow", Q, 8'h0F);
        apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("z_done", {7'd0, DONE}, 8'h01);
        chk("z_nowrap", Q, 8'h00);

        // Zero reload value never free-runs
        apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("zr_done", {7'd0, DONE}, 8'h01);

        // Auto-reload period 5
        apply(1'b0, 8'h04, 1'b1, 1'b1, 1'b1);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
            if (TC) pulses++;
            if (k == 5) chk("ar_reload", Q, 8'h04);
        end
        chk("ar_pulses", pulses[7:0], 8'd4);
        chk("ar_done", {7'd0, DONE}, 8'h00);

        // Pause on CEP, TC gated by CET, load beats count
        apply(1'b0, 8'h08, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("en_06", Q, 8'h06);
        for (int i = 0; i < 3; i++) apply(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("frozen", Q, 8'h06);
        for (int i = 0; i < 6; i++) apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("en_00", Q, 8'h00);
        chk("en_tc1", {7'd0, TC}, 8'h01);
        CET = 1'b0;
        #1;
        chk("cet_tc0", {7'd0, TC}, 8'h00);
        apply(1'b0, 8'h20, 1'b1, 1'b1, 1'b0);
        chk("ld_prio", Q, 8'h20);
        apply(1'b0, 8'h20, 1'b1, 1'b1, 1'b0);
        chk("ld_prio2", Q, 8'h20);

        // Restart from DONE
        apply(1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("rs_done", {7'd0, DONE}, 8'h01);
        apply(1'b0, 8'h02, 1'b1, 1'b1, 1'b0);
        chk("rs_q", Q, 8'h02);
        chk("rs_nd", {7'd0, DONE}, 8'h00);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("rs_00", Q, 8'h00);
        apply(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("rs_exp", {7'd0, DONE}, 8'h01);

        @(negedge CP);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bit8_down_timer_v.md
# bit8_down_timer_v

8-bit synchronous presettable down counter/timer, the count-down companion to the team's 74163-based 8-bit up counter. It is loaded with a start value, decrements on enabled clock edges, and signals expiry through a 74-style ripple terminal count (TC). A reload register supports optional auto-reload for periodic ticks. It is used for programmable delays and frequency division in the lab datapaths.

## Interface
- No parameters; width is fixed at 8 bits, organised as two 4-bit nibble stages.
- CP  input  1  clock; all state changes on the rising edge.
- MR  input  1  master reset; asynchronous, active-high.
- PEn  input  1  synchronous parallel load, active low.
- D  input  8  load value, D[7:0].
- CET  input  1  count enable trickle; also gates TC.
- CEP  input  1  count enable parallel.
- ARE  input  1  auto-reload enable; sampled on the expiry edge.
- Q  output  8  current count, registered.
- TC  output  1  terminal count / borrow out, combinational.
- DONE  output  1  high while the timer is expired; decoded from state.

## Operation
- Registers:
  - Q[7:0]
  - RLD[7:0], the reload value
  - 2-bit state: IDLE, RUN, DONE.
- Priority: MR (async) > PEn load > count.
- Effective count enable: `en = CET & CEP & (state == RUN)`.
- Nibble structure:
  - The low nibble decrements on en.
  - The high nibble decrements only when en is high and the low nibble is 0x0 (internal borrow).
  - Net effect is Q - 1 modulo 256; no other carry path exists.
- IDLE (after reset):
  - Q holds 0, counting is ignored, TC = 0, DONE = 0.
  - PEn = 0 → Q <= D, RLD <= D, state <= RUN.
- RUN:
  - PEn = 0 → reload Q and RLD from D; stay RUN.
  - en with Q != 0 → Q <= Q - 1.
  - en with Q == 0 and ARE = 1 and RLD != 0 → Q <= RLD; stay RUN.
  - en with Q == 0 and (ARE = 0 or RLD == 0) → state <= DONE; Q stays 0.
  - en = 0 → hold.
- DONE:
  - Q holds 0 and counting is ignored.
  - PEn = 0 → Q <= D, RLD <= D, state <= RUN.
- TC = CET & (Q == 0) & (state == RUN). This allows a second stage to be cascaded on CET/CEP exactly like the up counter.
- DONE = (state == DONE).
- Loading D = 0 is legal: it enters RUN with Q = 0, and the next en edge moves to DONE. With ARE = 1 and RLD = 0, the block still goes to DONE and never free-runs.
- Q never wraps 0x00 → 0xFF. The only transitions out of 0 are reload, load, or expiry.

## Timing
- Reset values (immediately on MR = 1, independent of CP): Q = 0x00, RLD = 0x00, state = IDLE, TC = 0, DONE = 0.
- MR deassertion: the first rising edge with MR = 0 is the first functional edge.
- Load latency: 1 edge. Q = D after the edge where PEn = 0 is sampled.
- Simultaneous PEn = 0 and en: load wins; no decrement on that edge.
- Count latency: Q changes 1 edge after en is sampled.
- TC is combinational from Q, state and CET, with no register delay. It is valid in the same cycle Q reaches 0.
- One-shot mode (ARE = 0): load N at edge 0, then CET = CEP = 1.
  - Q reaches 0 after N edges; TC is high during that cycle.
  - DONE rises at edge N+1.
- Auto-reload mode (ARE = 1): period is RLD + 1 enabled edges. TC pulses for one enabled cycle per period.
- Pausing: CET = 0 or CEP = 0 freezes Q. CET = 0 also forces TC = 0 (74163 semantics).
- MR asserted mid-count: immediate return to reset values; RLD is lost.

## Test plan
- Reset:
  - Assert MR asynchronously between edges with Q = 0x5A in RUN → Q = 0x00, state IDLE, DONE = 0, TC = 0 before the next edge.
  - Pulse CET = CEP = 1 for 5 edges → Q stays 0x00.
- One-shot:
  - Load 0x03 (ARE = 0), then enable → Q sequence 03, 02, 01, 00.
  - TC = 1 only in the 00 cycle; DONE = 1 after the next edge; Q stays 00 for 10 more edges.
- Nibble borrow:
  - Load 0x10, enable one edge → Q = 0x0F.
  - Load 0x00, ARE = 0, enable one edge → DONE = 1, Q = 0x00 (no wrap to 0xFF).
- Auto-reload:
  - Load 0x04, ARE = 1, enable for 20 edges → Q cycles 04..00 repeatedly.
  - TC pulses every 5 edges (4 pulses); DONE stays 0.
- Enables and priority:
  - During a count from 0x08, drop CEP for 3 edges → Q frozen.
  - Drop CET at Q = 0 → TC = 0.
  - Assert PEn = 0 with D = 0x20 and en = 1 on the same edge → Q = 0x20, no decrement.
- Restart from DONE:
  - In DONE, load 0x02 → state RUN, DONE = 0 one edge later, and counting resumes to expiry.
